// File: rtl/multiword_addsub_sequencer.sv
// Multi-precision add/subtract sequenced through one SIZE-bit ripple-carry slice,
// one word per clock (LSW first), with the inter-word carry held in a register.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module multiword_addsub_sequencer #(
    parameter int SIZE  = 4,
    parameter int WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  ctrl,
    input  logic [SIZE*WORDS-1:0] a,
    input  logic [SIZE*WORDS-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [SIZE*WORDS-1:0] result,
    output logic                  cout,
    output logic                  ovf,
    output logic [1:0]            dbg_state
);
    localparam int N  = SIZE * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Handshake: a command is accepted on a rising edge where start=1 and busy=0;
    // busy stays high until the edge after the one-cycle done pulse, and start is
    // ignored (operands not sampled) whenever busy=1.

    logic [1:0]    state;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          ctrl_q;
    logic          carry_reg;
    logic [IW-1:0] idx;

    logic [SIZE-1:0] a_w;
    logic [SIZE-1:0] b_w;
    logic [SIZE-1:0] sum;
    logic [SIZE:0]   c;
    logic            last;

    assign a_w  = a_q[idx*SIZE +: SIZE];
    assign b_w  = b_q[idx*SIZE +: SIZE] ^ {SIZE{ctrl_q}};
    assign c[0] = carry_reg;
    assign last = (idx == IW'(WORDS - 1));

    for (genvar i = 0; i < SIZE; i++) begin : g_slice
        full_adder u_fa (
            .a    (a_w[i]),
            .b    (b_w[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        ctrl_q    <= ctrl;
                        carry_reg <= ctrl;
                        idx       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    result[idx*SIZE +: SIZE] <= sum;
                    carry_reg                <= c[SIZE];
                    if (last) begin
                        cout  <= c[SIZE];
                        // Signed overflow: carry into the MSB disagrees with carry out.
                        ovf   <= c[SIZE-1] ^ c[SIZE];
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
